// File: rtl/sub_12_12_bit_pipe_pkg.sv
// Shared arithmetic settings for the sliced 12-bit subtractor pipeline.
//   SUB_WIDTH      : default total operand width
//   SUB_SLICE      : default width of one subtractor slice
//   SUB_NUM_SLICES : number of slices making up one operand
package sub_12_12_bit_pipe_pkg;

    localparam int SUB_WIDTH      = 12;
    localparam int SUB_SLICE      = 6;
    localparam int SUB_NUM_SLICES = SUB_WIDTH / SUB_SLICE;

endpackage

// File: rtl/sub_12_12_bit_pipe_slice.sv
// One combinational subtractor slice: {bout, result} = a - b - bin.
// Ports:
//   a, b   : SLICE-bit unsigned operands
//   bin    : borrow in from the less significant slice
//   result : (a - b - bin) mod 2^SLICE
//   bout   : 1 when a < b + bin
module sub_6_6_6_bits
    import sub_12_12_bit_pipe_pkg::*;
#(
    parameter int SLICE = SUB_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] result,
    output logic             bout
);

    // One extra bit wide: a true difference of at least -2^SLICE leaves the
    // extra MSB set exactly when the slice borrows.
    logic [SLICE:0] wide;

    always_comb begin
        wide   = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
        result = wide[SLICE-1:0];
        bout   = wide[SLICE];
    end

endmodule

// File: rtl/sub_12_12_bit_pipe.sv
// Two-stage pipelined unsigned subtractor: diff = (a - b) mod 2^WIDTH.
// Stage 1 subtracts the low slice and carries the high operand halves plus
// the low borrow; stage 2 subtracts the high slice and holds the result.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b)
//   out_valid/out_ready  : result handshake (diff, borrow_out)
//   borrow_out           : 1 when a < b unsigned
// WIDTH must equal 2*SLICE.
module sub_12_12_bit_pipe
    import sub_12_12_bit_pipe_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic             s1_valid;
    logic [SLICE-1:0] s1_d_lo;
    logic             s1_borrow_lo;
    logic [SLICE-1:0] s1_a_hi;
    logic [SLICE-1:0] s1_b_hi;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_diff;
    logic             s2_borrow;

    logic             s2_ready;
    logic             s1_adv;
    logic             accept;

    logic [SLICE-1:0] lo_result;
    logic             lo_bout;
    logic [SLICE-1:0] hi_result;
    logic             hi_bout;

    // Readiness ripples back combinationally from out_ready; there is no skid
    // buffer, so a full pipe stalls the input in the same cycle.
    assign s2_ready = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign accept   = in_valid && in_ready;

    sub_6_6_6_bits #(.SLICE(SLICE)) u_slice_lo (
        .a      (a[SLICE-1:0]),
        .b      (b[SLICE-1:0]),
        .bin    (1'b0),
        .result (lo_result),
        .bout   (lo_bout)
    );

    sub_6_6_6_bits #(.SLICE(SLICE)) u_slice_hi (
        .a      (s1_a_hi),
        .b      (s1_b_hi),
        .bin    (s1_borrow_lo),
        .result (hi_result),
        .bout   (hi_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_d_lo      <= '0;
            s1_borrow_lo <= 1'b0;
            s1_a_hi      <= '0;
            s1_b_hi      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_d_lo      <= lo_result;
                s1_borrow_lo <= lo_bout;
                s1_a_hi      <= a[WIDTH-1:SLICE];
                s1_b_hi      <= b[WIDTH-1:SLICE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                s2_diff   <= {hi_result, s1_d_lo};
                s2_borrow <= hi_bout;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign diff       = s2_diff;
    assign borrow_out = s2_borrow;

endmodule

// File: tb/tb_sub_12_12_bit_pipe.sv
module tb_sub_12_12_bit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a;
    logic [11:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] diff;
    logic        borrow_out;

    int errors = 0;
    int checks = 0;

    // Expected results in order: {borrow, diff}
    logic [12:0] q[$];

    sub_12_12_bit_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, sample handshake/outputs just
    // after, score any consumed result, record any accepted operand pair,
    // then advance to the next falling edge.
    task automatic step(input logic iv, input logic [11:0] ia, input logic [11:0] ib,
                        input logic ordy, input logic [12:0] expv,
                        output logic acc, output logic cons);
        logic [12:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        acc  = iv && in_ready;
        cons = out_valid && ordy;
        if (cons) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out_unexpected: observed diff=%0h borrow=%0b expected=no output",
                       diff, borrow_out);
            end else begin
                e = q.pop_front();
                chk("diff", {20'd0, diff}, {20'd0, e[11:0]});
                chk("borrow", {31'd0, borrow_out}, {31'd0, e[12]});
            end
        end
        if (acc) q.push_back(expv);
        @(negedge clk);
    endtask

    logic        acc, cons;
    logic [11:0] held_diff;
    logic [11:0] ra, rb, rsum;
    int          accepted, cycles, consumed;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {20'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Latency: result visible exactly two cycles after acceptance
        step(1'b1, 12'h800, 12'h001, 1'b1, {1'b0, 12'h7FF}, acc, cons);
        chk("lat_accept", {31'd0, acc}, 32'd1);
        chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 12'h000, 12'h000, 1'b1, 13'h0, acc, cons);
        chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 12'h000, 12'h000, 1'b1, 13'h0, acc, cons);
        chk("lat_consumed", {31'd0, cons}, 32'd1);

        // Directed slice-boundary vectors
        step(1'b1, 12'h040, 12'h001, 1'b1, {1'b0, 12'h03F}, acc, cons);
        step(1'b1, 12'h000, 12'h001, 1'b1, {1'b1, 12'hFFF}, acc, cons);
        step(1'b1, 12'hABC, 12'hABC, 1'b1, {1'b0, 12'h000}, acc, cons);
        step(1'b1, 12'h000, 12'hFFF, 1'b1, {1'b1, 12'h001}, acc, cons);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 12'h0, 1'b1, 13'h0, acc, cons);
        chk("dir_drained", q.size(), 32'd0);

        // Back-to-back stream: results on four consecutive cycles
        consumed = 0;
        step(1'b1, 12'h005, 12'h003, 1'b1, {1'b0, 12'h002}, acc, cons);
        step(1'b1, 12'h003, 12'h005, 1'b1, {1'b1, 12'hFFE}, acc, cons);
        step(1'b1, 12'hFFF, 12'hFFF, 1'b1, {1'b0, 12'h000}, acc, cons);
        consumed += cons;
        step(1'b1, 12'h123, 12'h0FF, 1'b1, {1'b0, 12'h024}, acc, cons);
        consumed += cons;
        step(1'b0, 12'h0, 12'h0, 1'b1, 13'h0, acc, cons);
        consumed += cons;
        step(1'b0, 12'h0, 12'h0, 1'b1, 13'h0, acc, cons);
        consumed += cons;
        chk("stream_consecutive", consumed, 32'd4);
        chk("stream_drained", q.size(), 32'd0);

        // Backpressure: two accepted, third refused while the pipe is full
        step(1'b1, 12'h010, 12'h001, 1'b0, {1'b0, 12'h00F}, acc, cons);
        chk("bp_acc1", {31'd0, acc}, 32'd1);
        step(1'b1, 12'h001, 12'h010, 1'b0, {1'b1, 12'hFF1}, acc, cons);
        chk("bp_acc2", {31'd0, acc}, 32'd1);
        held_diff = 12'h00F;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 12'h555, 12'h0AA, 1'b0, {1'b0, 12'h4AB}, acc, cons);
            chk("bp_acc3_refused", {31'd0, acc}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_diff", {20'd0, diff}, {20'd0, held_diff});
            chk("bp_hold_borrow", {31'd0, borrow_out}, 32'd0);
        end
        consumed = 0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            step(accepted == 0, 12'h555, 12'h0AA, 1'b1, {1'b0, 12'h4AB}, acc, cons);
            accepted += acc;
            consumed += cons;
        end
        chk("bp_third_accepted", accepted, 32'd1);
        chk("bp_consumed", consumed, 32'd3);
        chk("bp_drained", q.size(), 32'd0);

        // Reset mid-flight with both stages valid
        step(1'b1, 12'h111, 12'h022, 1'b0, {1'b0, 12'h0EF}, acc, cons);
        step(1'b1, 12'h222, 12'h011, 1'b0, {1'b0, 12'h211}, acc, cons);
        step(1'b0, 12'h0, 12'h0, 1'b0, 13'h0, acc, cons);
        chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_diff", {20'd0, diff}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 12'h0, 12'h0, 1'b1, 13'h0, acc, cons);
        chk("mid_no_stale", {31'd0, out_valid}, 32'd0);

        // Round trip: (a+b) - b == a, random handshakes on both sides
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 10000) begin
            ra   = 12'($urandom_range(0, 4095));
            rb   = 12'($urandom_range(0, 4095));
            rsum = ra + rb;
            step($urandom_range(0, 3) != 0, rsum, rb, $urandom_range(0, 2) != 0,
                 {rsum < rb, ra}, acc, cons);
            accepted += acc;
            cycles++;
        end
        chk("rt_accepted", accepted, 32'd1000);
        cycles = 0;
        while (q.size() > 0 && cycles < 50) begin
            step(1'b0, 12'h0, 12'h0, 1'b1, 13'h0, acc, cons);
            cycles++;
        end
        chk("rt_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
